// File: rtl/npu_result_reader.sv
// NPU result read path: packs result bytes into 32-bit words, buffers them in a
// word FIFO and returns data/status over an Avalon-MM slave with read latency 1.
//
// state | meaning
// FILL  | collecting bytes; a completed word is pushed as soon as a slot exists
// HOLD  | completed word waiting on a full FIFO; byte input stalled
module npu_result_reader #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  res_data,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic        res_last,
   input  logic        chipselect,
   input  logic        read,
   input  logic        address,
   output logic [31:0] readdata,
   output logic        irq
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {FILL, HOLD} pack_state_t;

   pack_state_t state, state_n;

   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count, count_n;
   logic [31:0]      pack, pack_ins, word_reg;
   logic [1:0]       idx;
   logic             pend, pend_last;
   logic             done, done_n, underflow, underflow_n;
   logic             empty, full;
   logic             accept, complete, push, pop;
   logic             data_rd, stat_rd;
   logic [31:0]      status;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign res_ready = reset && !(pend && full);
   assign accept    = res_valid && res_ready;
   assign complete  = accept && ((idx == 2'd3) || res_last);
   assign data_rd   = chipselect && read && !address;
   assign stat_rd   = chipselect && read && address;
   assign pop       = data_rd && !empty;

   always_comb begin
      pack_ins = pack;
      pack_ins[{idx, 3'b000} +: 8] = res_data;
   end

   // A pop in the same cycle frees the slot that a held word needs.
   always_comb begin
      state_n = state;
      push    = 1'b0;
      case (state)
         FILL: begin
            if (pend) begin
               if (!full || pop) push = 1'b1;
               else              state_n = HOLD;
            end
         end
         HOLD: begin
            if (pop) begin
               push    = 1'b1;
               state_n = FILL;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase
   end

   // A batch-end push outranks a concurrent STATUS clear so the event is not lost.
   always_comb begin
      done_n = done;
      if (push && pend_last) done_n = 1'b1;
      else if (stat_rd)      done_n = 1'b0;
      underflow_n = underflow;
      if (data_rd && empty)  underflow_n = 1'b1;
      else if (stat_rd)      underflow_n = 1'b0;
   end

   always_comb begin
      status            = '0;
      status[CNT_W-1:0] = count;
      status[17:16]     = idx;
      status[24]        = empty;
      status[25]        = full;
      status[26]        = done;
      status[27]        = underflow;
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= FILL;
      else        state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word_reg;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         pack      <= '0;
         word_reg  <= '0;
         idx       <= '0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
         done      <= 1'b0;
         underflow <= 1'b0;
         readdata  <= '0;
         irq       <= 1'b0;
      end else begin
         if (accept) begin
            if (complete) begin
               word_reg <= pack_ins;
               pack     <= '0;
               idx      <= '0;
            end else begin
               pack <= pack_ins;
               idx  <= idx + 2'd1;
            end
         end
         if (complete) begin
            pend      <= 1'b1;
            pend_last <= res_last;
         end else if (push) begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count     <= count_n;
         done      <= done_n;
         underflow <= underflow_n;
         irq       <= done_n && (count_n != '0);
         if (pop)          readdata <= mem[rd_ptr];
         else if (data_rd) readdata <= 32'h0000_0000;
         else if (stat_rd) readdata <= status;
      end
   end
endmodule

// File: tb/tb_npu_result_reader.sv
// Directed self-checking bench for npu_result_reader: packing, FIFO full/hold,
// underflow, streaming with wrap, and mid-operation reset.
module tb_npu_result_reader;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  res_data;
   logic        res_valid, res_ready, res_last;
   logic        chipselect, read, address;
   logic [31:0] readdata;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   npu_result_reader #(.DEPTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
      .chipselect(chipselect), .read(read), .address(address),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      res_data  = b;
      res_last  = last;
      res_valid = 1'b1;
      while (!res_ready && n < 50) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL ready_timeout got=%0d cycles exp<50", n);
      end
      cycle();
      res_valid = 1'b0;
      res_last  = 1'b0;
   endtask

   task automatic bus_read(input logic addr, output logic [31:0] d);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = addr;
      cycle();
      chipselect = 1'b0;
      read       = 1'b0;
      d          = readdata;
   endtask

   function automatic logic [31:0] fill_word(input int k);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(8'h10 + 4*k);
      b1 = 8'(8'h10 + 4*k + 1);
      b2 = 8'(8'h10 + 4*k + 2);
      b3 = 8'(8'h10 + 4*k + 3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0; res_data = '0; res_valid = 1'b0; res_last = 1'b0;
      chipselect = 1'b0; read = 1'b0; address = 1'b0;
      repeat (3) cycle();
      checks++;
      if (res_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", res_ready); end
      checks++;
      if (readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
      reset = 1'b1;
      cycle();
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0100_0000) begin failures++; $display("FAIL rst_status got=%h exp=01000000", d); end
   endtask

   task automatic test_pack();
      logic [31:0] d;
      send_byte(8'h33, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h0F, 1'b0);
      repeat (2) cycle();
      bus_read(1'b0, d);
      checks++;
      if (d !== 32'h0F00_0133) begin failures++; $display("FAIL pack_data got=%h exp=0f000133", d); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0100_0000) begin failures++; $display("FAIL pack_status got=%h exp=01000000", d); end
   endtask

   task automatic test_last();
      logic [31:0] d;
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      repeat (2) cycle();
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL last_irq_set got=%b exp=1", irq); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0400_0001) begin failures++; $display("FAIL last_status1 got=%h exp=04000001", d); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0000_0001) begin failures++; $display("FAIL last_status2 got=%h exp=00000001", d); end
      cycle();
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL last_irq_clr got=%b exp=0", irq); end
      bus_read(1'b0, d);
      checks++;
      if (d !== 32'h0000_BBAA) begin failures++; $display("FAIL last_data got=%h exp=0000bbaa", d); end
   endtask

   task automatic test_underflow();
      logic [31:0] d;
      bus_read(1'b0, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL uf_data got=%h exp=0", d); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0900_0000) begin failures++; $display("FAIL uf_status got=%h exp=09000000", d); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0100_0000) begin failures++; $display("FAIL uf_clear got=%h exp=01000000", d); end
   endtask

   task automatic test_fill_hold();
      logic [31:0] d;
      for (int i = 0; i < 36; i++) send_byte(8'(8'h10 + i), 1'b0);
      repeat (2) cycle();
      checks++;
      if (res_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", res_ready); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0200_0008) begin failures++; $display("FAIL hold_status got=%h exp=02000008", d); end
      bus_read(1'b0, d);
      checks++;
      if (d !== fill_word(0)) begin failures++; $display("FAIL hold_word0 got=%h exp=%h", d, fill_word(0)); end
      checks++;
      if (res_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%b exp=1", res_ready); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0200_0008) begin failures++; $display("FAIL hold_count got=%h exp=02000008", d); end
      for (int k = 1; k <= 8; k++) begin
         bus_read(1'b0, d);
         checks++;
         if (d !== fill_word(k)) begin
            failures++;
            $display("FAIL hold_word%0d got=%h exp=%h", k, d, fill_word(k));
         end
      end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0100_0000) begin failures++; $display("FAIL hold_drained got=%h exp=01000000", d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  bytes [40];
      logic [31:0] d;
      int stalls = 0;
      for (int i = 0; i < 40; i++) bytes[i] = 8'(i * 7 + 3);
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               res_data  = bytes[i];
               res_valid = 1'b1;
               if (!res_ready) stalls++;
               cycle();
            end
            res_valid = 1'b0;
         end
         begin
            logic [31:0] exp_w;
            repeat (6) cycle();
            for (int j = 0; j < 10; j++) begin
               exp_w = {bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]};
               chipselect = 1'b1;
               read       = 1'b1;
               address    = 1'b0;
               cycle();
               chipselect = 1'b0;
               read       = 1'b0;
               checks++;
               if (readdata !== exp_w) begin
                  failures++;
                  $display("FAIL b2b_word%0d got=%h exp=%h", j, readdata, exp_w);
               end
               repeat (3) cycle();
            end
         end
      join
      checks++;
      if (stalls !== 0) begin failures++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0100_0000) begin failures++; $display("FAIL b2b_status got=%h exp=01000000", d); end
   endtask

   task automatic test_mid_reset();
      logic [31:0] d;
      for (int i = 0; i < 14; i++) send_byte(8'(8'h50 + i), 1'b0);
      repeat (2) cycle();
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0002_0003) begin failures++; $display("FAIL mrst_pre got=%h exp=00020003", d); end
      reset = 1'b0;
      cycle();
      checks++;
      if (res_ready !== 1'b0) begin failures++; $display("FAIL mrst_ready got=%b exp=0", res_ready); end
      cycle();
      reset = 1'b1;
      cycle();
      bus_read(1'b1, d);
      checks++;
      if (d !== 32'h0100_0000) begin failures++; $display("FAIL mrst_status got=%h exp=01000000", d); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL mrst_irq got=%b exp=0", irq); end
   endtask

   initial begin
      test_reset();
      test_pack();
      test_last();
      test_underflow();
      test_fill_hold();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
